// File: rtl/morse_pkg.sv
// Shared Morse symbol codes, ASCII constants, FSM states and the {len, pat} to ASCII lookup.
// The digit map is included only when MORSE_DIGITS_EN is defined.
package morse_pkg;

  localparam logic [2:0] SYM_WAIT  = 3'd0;
  localparam logic [2:0] SYM_DIT   = 3'd1;
  localparam logic [2:0] SYM_DAH   = 3'd2;
  localparam logic [2:0] SYM_GAP   = 3'd3;
  localparam logic [2:0] SYM_SPACE = 3'd4;

  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic {ST_COLLECT, ST_FLUSH_SPACE} state_t;

  // pat bit i holds element i (first element in bit 0), 1 = dah.
  function automatic logic [7:0] morse_lookup(input logic [2:0] len, input logic [5:0] pat);
    logic [7:0] ch;
    ch = ASCII_QMARK;
    case ({len, pat})
      {3'd1, 6'd0}:  ch = 8'h45; // E
      {3'd1, 6'd1}:  ch = 8'h54; // T
      {3'd2, 6'd2}:  ch = 8'h41; // A
      {3'd2, 6'd0}:  ch = 8'h49; // I
      {3'd2, 6'd3}:  ch = 8'h4D; // M
      {3'd2, 6'd1}:  ch = 8'h4E; // N
      {3'd3, 6'd1}:  ch = 8'h44; // D
      {3'd3, 6'd3}:  ch = 8'h47; // G
      {3'd3, 6'd5}:  ch = 8'h4B; // K
      {3'd3, 6'd7}:  ch = 8'h4F; // O
      {3'd3, 6'd2}:  ch = 8'h52; // R
      {3'd3, 6'd0}:  ch = 8'h53; // S
      {3'd3, 6'd4}:  ch = 8'h55; // U
      {3'd3, 6'd6}:  ch = 8'h57; // W
      {3'd4, 6'd1}:  ch = 8'h42; // B
      {3'd4, 6'd5}:  ch = 8'h43; // C
      {3'd4, 6'd4}:  ch = 8'h46; // F
      {3'd4, 6'd0}:  ch = 8'h48; // H
      {3'd4, 6'd14}: ch = 8'h4A; // J
      {3'd4, 6'd2}:  ch = 8'h4C; // L
      {3'd4, 6'd6}:  ch = 8'h50; // P
      {3'd4, 6'd11}: ch = 8'h51; // Q
      {3'd4, 6'd8}:  ch = 8'h56; // V
      {3'd4, 6'd9}:  ch = 8'h58; // X
      {3'd4, 6'd13}: ch = 8'h59; // Y
      {3'd4, 6'd3}:  ch = 8'h5A; // Z
`ifdef MORSE_DIGITS_EN
      {3'd5, 6'd31}: ch = 8'h30;
      {3'd5, 6'd30}: ch = 8'h31;
      {3'd5, 6'd28}: ch = 8'h32;
      {3'd5, 6'd24}: ch = 8'h33;
      {3'd5, 6'd16}: ch = 8'h34;
      {3'd5, 6'd0}:  ch = 8'h35;
      {3'd5, 6'd1}:  ch = 8'h36;
      {3'd5, 6'd3}:  ch = 8'h37;
      {3'd5, 6'd7}:  ch = 8'h38;
      {3'd5, 6'd15}: ch = 8'h39;
`endif
      default:       ch = ASCII_QMARK;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/morse_char_assembler_fifo.sv
// Synchronous 8-bit character FIFO; head is read straight from registered storage.
// A push while full only lands if a pop happens on the same edge.
module char_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
endmodule

// File: rtl/morse_char_assembler.sv
// Assembles dit/dah/gap/space events into ASCII characters queued in an output FIFO.
// Digits 0-9 are decoded only when MORSE_DIGITS_EN is defined.
module morse_char_assembler
  import morse_pkg::*;
#(
  parameter int MAX_LEN    = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sym,
  output logic [7:0] char_data,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       overflow
);
  localparam logic [2:0] LEN_MAX = 3'(MAX_LEN);

  state_t             state, state_nx;
  logic [2:0]         sym_q, sym_prev;
  logic [MAX_LEN-1:0] pat, pat_nx;
  logic [2:0]         len, len_nx;
  logic               bad, bad_nx;
  logic [7:0]         last_push;
  logic               push, capture, evt, pop, full, empty;
  logic [7:0]         push_dat, cur_char;

  assign evt        = (sym_q != SYM_WAIT) && (sym_q != sym_prev);
  assign cur_char   = bad ? ASCII_QMARK : morse_lookup(len, 6'(pat));
  assign char_valid = !empty;
  assign pop        = char_valid && char_ready;

  always_comb begin
    state_nx = state;
    pat_nx   = pat;
    len_nx   = len;
    bad_nx   = bad;
    push     = 1'b0;
    push_dat = ASCII_SPACE;
    capture  = 1'b1;
    case (state)
      ST_FLUSH_SPACE: begin
        // Input sampling pauses so a symbol arriving now is not mistaken for a new edge.
        capture  = 1'b0;
        push     = 1'b1;
        state_nx = ST_COLLECT;
      end
      default: begin
        if (evt) begin
          case (sym_q)
            SYM_DIT, SYM_DAH: begin
              if (len == LEN_MAX) begin
                bad_nx = 1'b1;
              end else begin
                pat_nx[len] = (sym_q == SYM_DAH);
                len_nx      = len + 3'd1;
              end
            end
            SYM_GAP: begin
              push     = (len != 3'd0);
              push_dat = cur_char;
              pat_nx   = '0;
              len_nx   = 3'd0;
              bad_nx   = 1'b0;
            end
            SYM_SPACE: begin
              if (len != 3'd0) begin
                push     = 1'b1;
                push_dat = cur_char;
                pat_nx   = '0;
                len_nx   = 3'd0;
                bad_nx   = 1'b0;
                state_nx = ST_FLUSH_SPACE;
              end else begin
                push = (last_push != ASCII_SPACE);
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_COLLECT;
      sym_q     <= SYM_WAIT;
      sym_prev  <= SYM_WAIT;
      pat       <= '0;
      len       <= 3'd0;
      bad       <= 1'b0;
      last_push <= ASCII_SPACE;
      overflow  <= 1'b0;
    end else begin
      state <= state_nx;
      pat   <= pat_nx;
      len   <= len_nx;
      bad   <= bad_nx;
      if (capture) begin
        sym_q    <= sym;
        sym_prev <= sym_q;
      end
      if (push) last_push <= push_dat;
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  char_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_dat),
    .pop   (pop),
    .dout  (char_data),
    .full  (full),
    .empty (empty)
  );
endmodule

// File: doc/morse_char_assembler.md
# morse_char_assembler

Collects the dit/dah/gap/space symbol stream from the Morse symbol decoder and assembles each letter into an 8-bit ASCII character. Completed characters are written to a small output FIFO, which the display/UART stage drains through a valid/ready handshake. The block sits directly downstream of the symbol decoder and is the first stage that works in characters rather than timing.

## Interface
- `MAX_LEN`, 6: maximum number of dit/dah elements in one character (range 1..6).
- `FIFO_DEPTH`, 4: depth of the output character FIFO (power of 2, at least 2).
- `clk` in 1: system clock, shared with the symbol decoder.
- `rst_n` in 1: asynchronous, active-low reset.
- `sym` in 3: symbol code from the decoder; WAIT=0, DIT=1, DAH=2, GAP=3, SPACE=4; values 5..7 are ignored.
- `char_data` out 8: ASCII character at the FIFO head.
- `char_valid` out 1: the FIFO is not empty.
- `char_ready` in 1: the consumer accepts `char_data` on this edge.
- `overflow` out 1: sticky flag; a character was dropped because the FIFO was full.

## Operation
- Input capture: `sym` is registered into `sym_q` every cycle. An event fires when `sym_q` is not WAIT and `sym_q` differs from its previous registered value. This edge detection means a symbol held for several cycles counts once.
- Element storage: the pattern register `pat[MAX_LEN-1:0]` and the element counter `len` (0..MAX_LEN). A DIT writes 0 and a DAH writes 1 at bit index `len`, then `len` increments.
- Too many elements: a DIT or DAH that arrives with `len == MAX_LEN` sets the `bad` flag, and `len` saturates. When the character completes, `bad` forces the output to '?' (0x3F).
- Lookup: keyed by `{len, pat}`. It covers the 26 letters A-Z (uppercase). Any unmapped code gives '?'.
- GAP event:
  - If `len > 0`, push the looked-up character.
  - Clear `pat`, `len` and `bad`.
  - If `len == 0`, nothing is pushed.
- SPACE event:
  - If `len > 0`, push the character and enter FLUSH_SPACE.
  - Otherwise push 0x20 directly, unless the last character pushed was 0x20. Consecutive spaces collapse into one.
- FSM states:
  - COLLECT: normal operation.
  - FLUSH_SPACE: push 0x20 and return to COLLECT. Event detection is frozen for this cycle, so `sym_q` and the previous-sample register hold.
- FIFO push when full: the character is dropped and `overflow` is set. `overflow` is cleared only by reset.
- FIFO pop: occurs when `char_valid && char_ready`.
- FIFO full with push and pop on the same edge: both take effect, no drop occurs, and `overflow` is unchanged.
- Reset values:
  - Outputs: `char_valid=0`, `char_data=0x00`, `overflow=0`.
  - Internal state: FSM=COLLECT, `pat=0`, `len=0`, `bad=0`, FIFO empty, `sym_q=WAIT`, last-pushed register = 0x20, so leading spaces are suppressed.
- Reset asserted mid-character or mid-FLUSH_SPACE: all state is discarded immediately and nothing is pushed.

## Timing
- `sym` presented in cycle 0 is captured at edge 1. The event is processed at edge 2, which pushes the character. `char_valid` is high in cycle 2 when the FIFO was previously empty.
- SPACE with a pending character: the character is pushed at edge 2 and 0x20 at edge 3.
- `char_data` is registered and stable while `char_valid && !char_ready`. After a pop, the next entry appears in the following cycle.
- Throughput: one push per cycle; FLUSH_SPACE adds one push cycle.

## Configuration
- `MORSE_DIGITS_EN`:
  - Defined: the lookup also maps the 5-element digits 0-9 (0x30-0x39).
  - Undefined: digit codes give '?'.
- Letter decoding is identical in both builds.

## Structure
- Shared package `morse_pkg`:
  - Symbol codes WAIT/DIT/DAH/GAP/SPACE (3-bit).
  - ASCII constants for '?' and space.
  - FSM state enum.
- The lookup is a combinational function in the same package, so the decoder bench can reuse it.
- Sub-module `char_fifo`: synchronous FIFO, parameter `FIFO_DEPTH`, 8-bit data, with push/pop/full/empty signals and async active-low reset.

## Test plan
- Basic letter: DIT, DAH, GAP with `char_ready=1` -> one character 'A' (0x41). `char_valid` rises 2 cycles after GAP is presented.
- Word boundary: "-.-" then SPACE, then SPACE again -> 'K' (0x4B) followed by exactly one 0x20.
- Too many elements: 7 DITs then GAP (MAX_LEN=6) -> '?' (0x3F). A following DAH, GAP -> 'T' (0x54).
- Backpressure: `char_ready=0`, FIFO_DEPTH=4, five letters E,T,I,M,S -> FIFO holds E,T,I,M and `overflow=1`. After raising `char_ready`, the output order is E,T,I,M.
- Digits: "-----" then GAP -> '0' (0x30) with `MORSE_DIGITS_EN` defined, '?' without.
- Reset mid-character: DAH, DAH, then `rst_n` pulsed low, then DIT, GAP -> only 'E' (0x45) is output. `overflow=0` and `char_valid=0` during reset.
